// File: rtl/aes_vector_round_unit.sv
// AES round datapath that transforms LANES state columns per cycle.
// One operation at a time: accept in IDLE, ShiftRows on load, column passes in COL, hold result in DONE.
module aes_vector_round_unit #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_op,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_err,
    output logic         busy
);

    typedef enum logic [1:0] {S_IDLE, S_COL, S_DONE} fsm_t;

    localparam logic [1:0] LANE_STEP = 2'(LANES);
    localparam logic [1:0] LAST_COL  = 2'(4 - LANES);

    fsm_t         r_fsm;
    fsm_t         w_fsm_next;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [2:0]   r_op;
    logic [1:0]   r_col;
    logic         r_err;
    logic [127:0] w_next_state;
    logic         w_accept;
    logic         w_load_shift;
    logic         w_do_sub;
    logic         w_do_mix;
    logic         w_do_key;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse as x^254 (square-and-multiply), which maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] = s[127-32*((c+r)%4)-8*r -: 8];
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] col_xform(input logic [31:0] col, input logic [31:0] key,
                                              input logic do_sub, input logic do_mix,
                                              input logic do_key);
        logic [31:0] c;
        c = col;
        if (do_sub)
            for (int r = 0; r < 4; r++) c[31-8*r -: 8] = sbox(c[31-8*r -: 8]);
        if (do_mix) c = mix_col(c);
        if (do_key) c = c ^ key;
        return c;
    endfunction

    assign w_accept     = in_valid && (r_fsm == S_IDLE);
    assign w_load_shift = (in_op == 3'b010) || (in_op == 3'b100) || (in_op == 3'b101);
    assign w_do_sub     = (r_op == 3'b001) || (r_op == 3'b100) || (r_op == 3'b101);
    assign w_do_mix     = (r_op == 3'b011) || (r_op == 3'b100);
    assign w_do_key     = (r_op == 3'b000) || (r_op == 3'b100) || (r_op == 3'b101);

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_next_state = r_state;
        for (int l = 0; l < LANES; l++)
            w_next_state[127-32*(int'(r_col)+l) -: 32] =
                col_xform(r_state[127-32*(int'(r_col)+l) -: 32], r_key[127-32*(int'(r_col)+l) -: 32],
                          w_do_sub, w_do_mix, w_do_key);
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_fsm <= S_IDLE;
        else     r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (r_fsm)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_fsm_next = S_COL;
            end
            S_COL: begin
                if (r_col == LAST_COL) w_fsm_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_fsm_next = S_IDLE;
            end
            default: w_fsm_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
            r_key   <= '0;
            r_op    <= '0;
            r_col   <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_state <= w_load_shift ? shift_rows(in_state) : in_state;
            r_key   <= in_key;
            r_op    <= in_op;
            r_col   <= '0;
            r_err   <= in_op[2] & in_op[1];
        end else if (r_fsm == S_COL) begin
            r_state <= w_next_state;
            r_col   <= r_col + LANE_STEP;
        end
    end

    assign out_state = r_state;
    assign out_err   = r_err;

endmodule
